// File: rtl/mdu_hilo.sv
// -----------------------------------------------------------------------------
// mdu_hilo -- MIPS32 multiply/divide unit with architectural HI/LO registers.
//
// Sits beside the EX stage. MULT/MULTU finish in a single pass. DIV/DIVU use a
// bit-serial restoring divider (one quotient bit per cycle) followed by a
// sign-fixup cycle. MTHI/MTLO write HI/LO directly on the accepting edge.
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-low reset
//   start  in   op request, sampled on the rising edge while idle
//   op     in   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 ignored
//   a      in   rs value (dividend / multiplicand / MTHI/MTLO source)
//   b      in   rt value (divisor / multiplier)
//   busy   out  operation in flight; HI/LO not yet updated
//   done   out  one-cycle pulse on the cycle after HI/LO commit
//   hi     out  HI register
//   lo     out  LO register
// -----------------------------------------------------------------------------
module mdu_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  // opa holds the multiplicand, or the dividend that shifts out MSB-first
  // while quotient bits shift in at the bottom. opb holds multiplier/divisor.
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sgn_q, sgn_d;     // signed multiply
  logic             negq_q, negq_d;   // negate quotient at fixup
  logic             negr_q, negr_d;   // negate remainder at fixup
  logic             div0_q, div0_d;   // divide by zero: commit nothing

  logic [2*WIDTH-1:0] mul_a_ext, mul_b_ext, product;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH-1:0]   rem_sub;
  logic               rem_ge;
  logic               a_neg, b_neg, is_div_s;

  // Extending both operands to 2*WIDTH makes one unsigned multiply produce
  // the correct low 2*WIDTH bits for both signed and unsigned products.
  assign mul_a_ext = sgn_q ? {{WIDTH{opa_q[WIDTH-1]}}, opa_q} : {{WIDTH{1'b0}}, opa_q};
  assign mul_b_ext = sgn_q ? {{WIDTH{opb_q[WIDTH-1]}}, opb_q} : {{WIDTH{1'b0}}, opb_q};
  assign product   = mul_a_ext * mul_b_ext;

  // One restoring step. The shifted remainder needs an extra bit for the
  // compare; when it is >= divisor the difference always fits in WIDTH bits.
  assign rem_shift = {rem_q, opa_q[WIDTH-1]};
  assign rem_ge    = rem_shift >= {1'b0, opb_q};
  assign rem_sub   = rem_shift[WIDTH-1:0] - opb_q;

  assign is_div_s = (op == OP_DIV);
  assign a_neg    = is_div_s && a[WIDTH-1];
  assign b_neg    = is_div_s && b[WIDTH-1];

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    opa_d   = opa_q;
    opb_d   = opb_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    div0_d  = div0_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              opa_d   = a;
              opb_d   = b;
              sgn_d   = (op == OP_MULT);
              state_d = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
              if (b == '0) begin
                div0_d  = 1'b1;
                state_d = S_FIX;
              end else begin
                // |-2^(W-1)| wraps to itself, which is the correct unsigned
                // magnitude, so the overflow case needs no special handling.
                opa_d   = a_neg ? -a : a;
                opb_d   = b_neg ? -b : b;
                negq_d  = a_neg ^ b_neg;
                negr_d  = a_neg;
                div0_d  = 1'b0;
                rem_d   = '0;
                cnt_d   = '0;
                state_d = S_DIV;
              end
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;  // 6/7 are not MDU ops
          endcase
        end
      end

      S_MUL: begin
        {hi_d, lo_d} = product;
        done_d       = 1'b1;
        state_d      = S_IDLE;
      end

      S_DIV: begin
        if (rem_ge) begin
          rem_d = rem_sub;
          opa_d = {opa_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_shift[WIDTH-1:0];
          opa_d = {opa_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) state_d = S_FIX;
      end

      S_FIX: begin
        if (!div0_q) begin
          lo_d = negq_q ? -opa_q : opa_q;
          hi_d = negr_q ? -rem_q : rem_q;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values of the others, independent of statement order.
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      div0_q  <= div0_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// -----------------------------------------------------------------------------
// tb_mdu_hilo -- self-checking bench for mdu_hilo.
//
// The driver issues ops and pushes the expected HI/LO into a scoreboard queue;
// a separate monitor pops and compares whenever done pulses. Expected values
// come from plain 64-bit arithmetic on the architectural MIPS rules.
// -----------------------------------------------------------------------------
module tb_mdu_hilo;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  mdu_hilo #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    string        name;
  } exp_t;

  exp_t         sb_q[$];
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  int           checks = 0;
  int           failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Architectural reference: HI/LO after the op, given current HI/LO.
  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, y,
                                 input logic [W-1:0] cur_hi, cur_lo);
    exp_t        e;
    longint      sx, sy, q, r;
    logic [63:0] p, qv, rv;
    e.hi = cur_hi;
    e.lo = cur_lo;
    e.name = $sformatf("op%0d a=%0h b=%0h", o, x, y);
    case (o)
      3'd0: begin
        p = 64'(longint'($signed(x)) * longint'($signed(y)));
        e.hi = p[63:32]; e.lo = p[31:0];
      end
      3'd1: begin
        p = {32'b0, x} * {32'b0, y};
        e.hi = p[63:32]; e.lo = p[31:0];
      end
      3'd2, 3'd3: begin
        if (y != '0) begin
          if (o == 3'd2) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
          end else begin
            sx = longint'({32'b0, x});
            sy = longint'({32'b0, y});
          end
          q = sx / sy;  // truncates toward zero; remainder takes dividend sign
          r = sx % sy;
          qv = 64'(q);
          rv = 64'(r);
          e.lo = qv[31:0];
          e.hi = rv[31:0];
        end
      end
      3'd4: e.hi = x;
      3'd5: e.lo = x;
      default: ;
    endcase
    return e;
  endfunction

  function automatic int exp_busy(input logic [2:0] o, input logic [W-1:0] y);
    if (o <= 3'd1) return 1;
    if (o <= 3'd3) return (y == '0) ? 1 : W + 1;
    return 0;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst && done) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 with no op outstanding, required done=0");
      end else begin
        e = sb_q.pop_front();
        check({e.name, " hi"}, 64'(hi), 64'(e.hi));
        check({e.name, " lo"}, 64'(lo), 64'(e.lo));
        check({e.name, " busy_at_done"}, 64'(busy), 64'd0);
      end
    end
  end

  // Issue one op starting at a negedge; returns at the negedge where busy has
  // dropped (the done cycle for MDU ops), so a following call is back-to-back.
  // inject >= 0 pulses a MULT 9*9 at that busy cycle, which must be ignored.
  task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, y, input int inject);
    exp_t e;
    int   n;
    int   eb;
    logic held;
    e  = model(o, x, y, m_hi, m_lo);
    eb = exp_busy(o, y);
    if (o <= 3'd3) sb_q.push_back(e);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    if (o >= 3'd4) begin
      check({e.name, " direct hi"}, 64'(hi), 64'(e.hi));
      check({e.name, " direct lo"}, 64'(lo), 64'(e.lo));
      check({e.name, " no busy"}, 64'(busy), 64'd0);
      check({e.name, " no done"}, 64'(done), 64'd0);
    end else begin
      n = 0;
      held = 1'b1;
      while (busy && n < 100) begin
        if (hi !== m_hi || lo !== m_lo) held = 1'b0;
        if (n == inject) begin
          start = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9;
        end
        @(negedge clk);
        start = 1'b0;
        n++;
      end
      check({e.name, " busy_cycles"}, 64'(n), 64'(eb));
      check({e.name, " hold_while_busy"}, 64'(held), 64'd1);
    end
    m_hi = e.hi;
    m_lo = e.lo;
  endtask

  // Start a DIV and pull reset at busy cycle 10: everything clears at once.
  task automatic div_with_reset();
    start = 1'b1; op = 3'd2; a = 32'd1000000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("pre-reset busy", 64'(busy), 64'd1);
    rst = 1'b0;
    #1;
    check("mid-div reset busy", 64'(busy), 64'd0);
    check("mid-div reset done", 64'(done), 64'd0);
    check("mid-div reset hi", 64'(hi), 64'd0);
    check("mid-div reset lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    m_hi = '0;
    m_lo = '0;
    repeat (3) @(negedge clk);
    check("post-reset busy", 64'(busy), 64'd0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic [2:0]   ro;
    logic [W-1:0] rx, ry;
    rst = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("after release busy", 64'(busy), 64'd0);

    do_op(3'd0, 32'hFFFF_FFFE, 32'd3, -1);
    check("MULT hi literal", 64'(hi), 64'hFFFF_FFFF);
    check("MULT lo literal", 64'(lo), 64'hFFFF_FFFA);
    do_op(3'd1, 32'hFFFF_FFFE, 32'd3, -1);
    check("MULTU hi literal", 64'(hi), 64'h0000_0002);
    check("MULTU lo literal", 64'(lo), 64'hFFFF_FFFA);

    do_op(3'd2, 32'hFFFF_FFF9, 32'd2, -1);
    check("DIV -7/2 lo literal", 64'(lo), 64'hFFFF_FFFD);
    check("DIV -7/2 hi literal", 64'(hi), 64'hFFFF_FFFF);
    do_op(3'd3, 32'd100, 32'd7, -1);
    check("DIVU 100/7 lo literal", 64'(lo), 64'd14);
    check("DIVU 100/7 hi literal", 64'(hi), 64'd2);

    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    check("DIV overflow lo literal", 64'(lo), 64'h8000_0000);
    check("DIV overflow hi literal", 64'(hi), 64'd0);
    do_op(3'd3, 32'd5, 32'd0, -1);
    check("DIVU by zero lo unchanged", 64'(lo), 64'h8000_0000);
    check("DIVU by zero hi unchanged", 64'(hi), 64'd0);

    do_op(3'd2, 32'd1234567, 32'hFFFF_FFA7, 5);

    do_op(3'd4, 32'h1234_5678, '0, -1);
    do_op(3'd5, 32'hCAFE_BABE, '0, -1);
    check("MTHI literal", 64'(hi), 64'h1234_5678);
    do_op(3'd6, 32'h1111_1111, 32'd1, -1);
    do_op(3'd7, 32'h2222_2222, 32'd0, -1);

    // MULT issued in the DIVU done cycle must be accepted (busy_cycles == 1).
    do_op(3'd3, 32'd1000, 32'd7, -1);
    do_op(3'd0, 32'd9, 32'd9, -1);
    check("back-to-back MULT lo literal", 64'(lo), 64'd81);

    div_with_reset();

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      rx = $urandom;
      case ($urandom_range(0, 5))
        0: ry = '0;
        1: ry = 32'hFFFF_FFFF;
        2: ry = 32'($urandom_range(1, 20));
        default: ry = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) rx = 32'h8000_0000;
      do_op(ro, rx, ry, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1);
    end

    repeat (3) @(negedge clk);
    check("scoreboard drained", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
Multiply/divide unit with architectural HI/LO registers for the MIPS32 pipeline, sitting beside the EX stage downstream of the ID/EX register. Executes MULT/MULTU in a fixed 1-cycle pass and DIV/DIVU with a bit-serial restoring divider. Exposes busy so hazard logic can stall MFHI/MFLO and new MDU ops until results are committed. It is instantiated inside CPU and exercised through the existing clk/rst CPU bench.

Parameters:
WIDTH, 32, operand and HI/LO width; divider iterates WIDTH cycles

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  op request from EX stage, sampled on rising edge
op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 ignored
a  input  WIDTH  rs value (dividend / multiplicand / MTHI/MTLO source)
b  input  WIDTH  rt value (divisor / multiplier)
busy  output  1  operation in progress; HI/LO not yet updated
done  output  1  one-cycle pulse on the cycle after HI/LO commit
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (rst=0, async): hi=0, lo=0, busy=0, done=0, state IDLE, divider regs cleared. Reset mid-operation aborts; no partial commit.
- States: IDLE, MUL, DIV, FIX.
- Accept: start=1 and state IDLE and op<=5. Start while busy, or op 6/7, is ignored (no state change, no done).
- MTHI/MTLO: hi (or lo) <= a on accepting edge; busy stays 0; no done pulse.
- MULT/MULTU: accepting edge latches operands, IDLE->MUL, busy=1. Next edge: {hi,lo} <= 2*WIDTH product (signed for MULT, unsigned for MULTU), MUL->IDLE, busy=0, done=1 for that cycle. Total latency 2 edges.
- DIV/DIVU, b==0: IDLE->FIX directly; FIX edge returns to IDLE, hi/lo unchanged, done pulses. Busy for 1 cycle.
- DIV/DIVU, b!=0: accepting edge latches |a|,|b| (DIV) or a,b (DIVU) and sign flags, counter=0, IDLE->DIV. Each DIV edge: shift remainder left 1, bring in next dividend bit, subtract divisor if remainder>=divisor, set quotient bit. After WIDTH iterations -> FIX. FIX edge: DIV negates quotient if signs differ, remainder takes dividend sign; lo<=quotient, hi<=remainder; ->IDLE, done=1. Busy for WIDTH+1 cycles (33 at default).
- DIV overflow -2^31 / -1: lo=0x80000000, hi=0 (two's-complement wrap, no trap).
- hi/lo hold previous values while busy; only the commit edge changes them.
- Back-to-back: in the done cycle state is IDLE, so start is accepted that cycle.
- done is registered; never asserted in same cycle as busy.

Test Plan:
- Reset: hold rst=0 then release -> hi=0, lo=0, busy=0, done=0; assert rst=0 mid-DIV (cycle 10) -> busy=0, hi=lo=0 immediately.
- MULT a=0xFFFFFFFE (-2), b=3 -> busy 1 cycle, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulse; MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=-7 (0xFFFFFFF9), b=2 -> busy exactly 33 cycles, lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU a=100, b=7 -> lo=14, hi=2.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU a=5, b=0 -> busy 1 cycle, hi/lo unchanged, done pulses.
- Start pulsed while busy during DIV (op=MULT, a=b=9) -> ignored; final hi/lo reflect only the DIV.
- MTHI a=0x12345678 then MTLO a=0xCAFEBABE on consecutive cycles -> hi/lo updated on each accepting edge, busy stays 0; MULT issued in DIV's done cycle is accepted.
